// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding and bus constants for the I2C target
package i2c_pkg;
  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    RX_DATA,
    RX_ACK,
    TX_DATA,
    TX_ACK,
    WAIT_STOP
  } state_t;
  localparam logic I2C_ACK = 1'b0;
  localparam logic I2C_NACK = 1'b1;
  localparam logic [6:0] DEFAULT_ADDR = 7'h50;
endpackage

// File: rtl/i2c_sync_edge.sv
// i2c_sync_edge: two-flop synchronizer with single-clk rise/fall pulses
module i2c_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [2:0] sr_q, sr_d;
  always_comb sr_d = rst ? 3'b111 : {sr_q[1:0], d};
  always_ff @(posedge clk) sr_q <= sr_d;
  assign q = sr_q[1];
  assign rise = sr_q[1] & ~sr_q[2];
  assign fall = ~sr_q[1] & sr_q[2];
endmodule

// File: rtl/i2c_slave.sv
// i2c_slave: I2C target acking SLAVE_ADDR and streaming bytes through rx/tx strobes
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = DEFAULT_ADDR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       o_rxff_wr,
  output logic       o_txff_rd,
  output logic       addr_match,
  output logic       i2c_busy,
  output logic       i2c_done
);
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d, data_q, data_d, sh_in;
  logic oe_q, oe_d, rw_q, rw_d, rx_q, rx_d, tx_q, tx_d;
  logic match_q, match_d, busy_q, busy_d, done_q, done_d;
  logic scl_s, scl_rise, scl_fall, sda_s, sda_rise, sda_fall, start, stop, hit;
  i2c_sync_edge u_scl (.clk(clk), .rst(rst), .d(scl), .q(scl_s), .rise(scl_rise), .fall(scl_fall));
  i2c_sync_edge u_sda (.clk(clk), .rst(rst), .d(sda), .q(sda_s), .rise(sda_rise), .fall(sda_fall));
  assign start = sda_fall & scl_s;
  assign stop = sda_rise & scl_s;
  assign sh_in = {sh_q[6:0], sda_s};
  assign hit = (sh_q[6:0] == SLAVE_ADDR) && (SLAVE_ADDR != 7'h00);
  assign sda = oe_q ? 1'b0 : 1'bz;
  assign data_out = data_q;
  assign o_rxff_wr = rx_q;
  assign o_txff_rd = tx_q;
  assign addr_match = match_q;
  assign i2c_busy = busy_q;
  assign i2c_done = done_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    sh_d = sh_q;
    data_d = data_q;
    oe_d = oe_q;
    rw_d = rw_q;
    rx_d = 1'b0;
    tx_d = 1'b0;
    match_d = match_q;
    busy_d = busy_q;
    done_d = 1'b0;
    case (state_q)
      ADDR: if (scl_rise) begin
        sh_d = sh_in;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd0) begin
          cnt_d = 4'd7;
          rw_d = sda_s;
          match_d = hit;
          state_d = hit ? ADDR_ACK : WAIT_STOP;
        end
      end
      ADDR_ACK, RX_ACK: if (scl_fall) begin
        oe_d = ~oe_q;
        if (oe_q) begin
          state_d = RX_DATA;
          if (state_q == ADDR_ACK && rw_q) begin
            tx_d = 1'b1;
            sh_d = {data_in[6:0], 1'b0};
            oe_d = ~data_in[7];
            cnt_d = 4'd7;
            state_d = TX_DATA;
          end
        end
      end
      RX_DATA: if (scl_rise) begin
        sh_d = sh_in;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd0) begin
          cnt_d = 4'd7;
          data_d = sh_in;
          rx_d = 1'b1;
          state_d = RX_ACK;
        end
      end
      TX_DATA: if (scl_fall) begin
        oe_d = (cnt_q == 4'd0) ? 1'b0 : ~sh_q[7];
        sh_d = {sh_q[6:0], 1'b0};
        cnt_d = (cnt_q == 4'd0) ? cnt_q : cnt_q - 4'd1;
        state_d = (cnt_q == 4'd0) ? TX_ACK : TX_DATA;
      end
      TX_ACK: if (scl_rise) begin
        tx_d = (sda_s == I2C_ACK);
        sh_d = (sda_s == I2C_ACK) ? data_in : sh_q;
        cnt_d = 4'd8;
        state_d = (sda_s == I2C_ACK) ? TX_DATA : WAIT_STOP;
      end
      default: ;
    endcase
    if (start) begin
      state_d = ADDR;
      cnt_d = 4'd7;
      oe_d = 1'b0;
      match_d = 1'b0;
      busy_d = 1'b1;
    end else if (stop) begin
      state_d = IDLE;
      cnt_d = 4'd0;
      oe_d = 1'b0;
      match_d = 1'b0;
      busy_d = 1'b0;
      done_d = match_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sh_q <= '0;
      data_q <= '0;
      oe_q <= 1'b0;
      rw_q <= 1'b0;
      rx_q <= 1'b0;
      tx_q <= 1'b0;
      match_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      data_q <= data_d;
      oe_q <= oe_d;
      rw_q <= rw_d;
      rx_q <= rx_d;
      tx_q <= tx_d;
      match_q <= match_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
endmodule
